// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared types and constants for the RAM clear/arbiter slice.
//   state_t        : controller state (SERVE, CLEAR)
//   PORT0 / PORT1  : requester IDs used by the round-robin pointer
//   DEF_*_WIDTH    : default RAM geometry
package ram_ctrl_pkg;

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int unsigned DEF_ADDR_WIDTH = 7;
  localparam int unsigned DEF_DATA_WIDTH = 16;

endpackage

// File: rtl/ram_sp_rf.sv
// ram_sp_rf: single-port, read-first synchronous RAM with a registered output.
// Contents start at zero (configuration-time initialisation).
// Ports:
//   clk_i  clock, rising edge
//   we_i   write enable
//   a_i    address
//   di_i   write data
//   do_o   registered read data (old contents on a write)
module ram_sp_rf
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] di_i,
  output logic [DATA_WIDTH-1:0] do_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  // Read and write in the same block: the read sees the pre-write contents.
  always_ff @(posedge clk_i) begin
    do_o <= mem_q[a_i];
    if (we_i) begin
      mem_q[a_i] <= di_i;
    end
  end

endmodule

// File: rtl/ram_clear_arbiter.sv
// ram_clear_arbiter: shares one read-first single-port RAM between two
// requesters with round-robin arbitration, plus a clear sequencer that writes
// zero to every location.
// Optional feature macro: RAM_CLR_ON_RESET_EN -- when defined, reset release
// starts a full clear sweep before the first grant.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   clr_start                  one-cycle request to start a clear
//   clr_busy, clr_done         sweep running / one-cycle completion pulse
//   pN_req, pN_we, pN_addr,
//   pN_wdata                   requester N access (held until granted)
//   pN_gnt                     combinational grant, access happens this edge
//   pN_rvalid                  rd_data holds the result of port N's read
//   rd_data                    shared RAM output register
module ram_clear_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

`ifdef RAM_CLR_ON_RESET_EN
  localparam state_t RST_STATE = CLEAR;
  localparam logic   RST_BUSY  = 1'b1;
`else
  localparam state_t RST_STATE = SERVE;
  localparam logic   RST_BUSY  = 1'b0;
`endif

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  clr_busy_q;
  logic                  clr_done_q;
  logic                  p0_rvalid_q;
  logic                  p1_rvalid_q;
  logic                  rr_last_q;

  logic                  serve_ok;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic [DATA_WIDTH-1:0] ram_di;

  // Grants and RAM port steering. clr_start blocks grants in its own cycle so
  // no access is in flight when the sweep begins.
  always_comb begin
    serve_ok = (state_q == SERVE) && !clr_start;
    p0_gnt   = serve_ok && p0_req && (!p1_req || (rr_last_q == PORT1));
    p1_gnt   = serve_ok && p1_req && (!p0_req || (rr_last_q == PORT0));

    ram_we = 1'b0;
    ram_a  = p0_addr;
    ram_di = p0_wdata;
    if (state_q == CLEAR) begin
      ram_we = 1'b1;
      ram_a  = clr_cnt_q;
      ram_di = '0;
    end else if (p1_gnt) begin
      ram_we = p1_we;
      ram_a  = p1_addr;
      ram_di = p1_wdata;
    end else if (p0_gnt) begin
      ram_we = p0_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      clr_cnt_q   <= '0;
      clr_busy_q  <= RST_BUSY;
      clr_done_q  <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      rr_last_q   <= PORT1;
    end else begin
      p0_rvalid_q <= p0_gnt && !p0_we;
      p1_rvalid_q <= p1_gnt && !p1_we;
      if (p0_gnt) begin
        rr_last_q <= PORT0;
      end else if (p1_gnt) begin
        rr_last_q <= PORT1;
      end

      clr_done_q <= 1'b0;
      case (state_q)
        SERVE: begin
          if (clr_start) begin
            state_q    <= CLEAR;
            clr_busy_q <= 1'b1;
            clr_cnt_q  <= '0;
          end
        end
        CLEAR: begin
          // clr_start is ignored here: the sweep neither restarts nor queues.
          if (clr_cnt_q == LAST_ADDR) begin
            state_q    <= SERVE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
            clr_cnt_q  <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign clr_busy  = clr_busy_q;
  assign clr_done  = clr_done_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;

  ram_sp_rf #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk_i(clk),
    .we_i (ram_we),
    .a_i  (ram_a),
    .di_i (ram_di),
    .do_o (rd_data)
  );

endmodule

// File: tb/tb_ram_clear_arbiter.sv
module tb_ram_clear_arbiter;

  localparam int AW    = 7;
  localparam int DW    = 16;
  localparam int DEPTH = 128;

`ifdef RAM_CLR_ON_RESET_EN
  localparam bit CLR_ON_RST = 1'b1;
`else
  localparam bit CLR_ON_RST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_start = 1'b0;
  logic          clr_busy, clr_done;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p0_gnt, p0_rvalid;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p1_gnt, p1_rvalid;
  logic [DW-1:0] rd_data;

  always #5 clk = ~clk;

  ram_clear_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .rd_data(rd_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory image, sweep progress, round-robin owner.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy, m_done, m_rv0, m_rv1, m_rd_chk;
  int            m_idx, m_rr, m_last_g;
  logic [DW-1:0] m_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Which port wins this cycle, -1 for none.
  function automatic int model_grant();
    if (m_busy || clr_start) return -1;
    if (p0_req && p1_req) return (m_rr == 0) ? 1 : 0;
    if (p0_req) return 0;
    if (p1_req) return 1;
    return -1;
  endfunction

  task automatic model_clock(input int g);
    int a;
    m_rv0    = (g == 0) && !p0_we;
    m_rv1    = (g == 1) && !p1_we;
    m_rd_chk = 1'b0;
    m_done   = 1'b0;
    if (m_busy) begin
      m_mem[m_idx] = '0;
      if (m_idx == DEPTH - 1) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end else if (clr_start) begin
      m_busy = 1'b1;
      m_idx  = 0;
    end else if (g >= 0) begin
      a        = (g == 1) ? int'(p1_addr) : int'(p0_addr);
      m_rd     = m_mem[a];
      m_rd_chk = 1'b1;
      m_rr     = g;
      if (g == 0 && p0_we) m_mem[a] = p0_wdata;
      if (g == 1 && p1_we) m_mem[a] = p1_wdata;
    end
  endtask

  // One clock: entered and left at posedge+1.
  task automatic step();
    int g;
    #4;
    g = model_grant();
    m_last_g = g;
    check("p0_gnt", 32'(p0_gnt), 32'(g == 0));
    check("p1_gnt", 32'(p1_gnt), 32'(g == 1));
    model_clock(g);
    @(posedge clk);
    #1;
    check("p0_rvalid", 32'(p0_rvalid), 32'(m_rv0));
    check("p1_rvalid", 32'(p1_rvalid), 32'(m_rv1));
    check("clr_busy", 32'(clr_busy), 32'(m_busy));
    check("clr_done", 32'(clr_done), 32'(m_done));
    if (m_rd_chk) check("rd_data", 32'(rd_data), 32'(m_rd));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(clr_busy), 32'(CLR_ON_RST));
    check("rst_done", 32'(clr_done), 32'd0);
    check("rst_rv0", 32'(p0_rvalid), 32'd0);
    check("rst_rv1", 32'(p1_rvalid), 32'd0);
    m_busy = CLR_ON_RST; m_idx = 0; m_done = 1'b0; m_rr = 1;
    m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd_chk = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    clr_start = 1'b0; p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2 * DEPTH && m_busy; i++) step();
  endtask

  task automatic p0_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d;
    step();
    p0_req = 1'b0; p0_we = 1'b0;
  endtask

  // Runs one sweep from the current cycle, returns number of busy cycles.
  task automatic count_sweep(output int cnt, input int restart_at);
    cnt = clr_busy ? 1 : 0;
    for (int i = 0; i < 3 * DEPTH && clr_busy; i++) begin
      clr_start = (i == restart_at);
      step();
      if (clr_busy) cnt++;
    end
    clr_start = 1'b0;
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_last_g = -1;
    @(posedge clk);
    #1;
    do_reset();
    wait_idle();

    // Write then read back on P0.
    p0_access(1'b1, 7'd5, 16'hBEEF);
    p0_access(1'b0, 7'd5, 16'h0);
    check("beef_rd", 32'(rd_data), 32'hBEEF);
    check("beef_p1rv", 32'(p1_rvalid), 32'd0);
    step();

    // Contention right after reset: P0 first, then alternate.
    do_reset();
    wait_idle();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 7'd5;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 7'd6;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_order", 32'(m_last_g), 32'(i % 2));
    end
    idle_inputs();
    step();

    // Full clear sweep after a write to the top address.
    p0_access(1'b1, 7'd127, 16'h1234);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    count_sweep(cnt, -1);
    check("sweep_len", 32'(cnt), 32'(DEPTH));
    p0_access(1'b0, 7'd0, 16'h0);
    check("clr_rd0", 32'(rd_data), 32'h0);
    p0_access(1'b0, 7'd127, 16'h0);
    check("clr_rd127", 32'(rd_data), 32'h0);

    // P1 waits through a sweep; a mid-sweep clr_start must not extend it.
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 7'd3;
    clr_start = 1'b1;
    step();
    count_sweep(cnt, 60);
    check("sweep_len2", 32'(cnt), 32'(DEPTH));
    check("done_pulse", 32'(clr_done), 32'd1);
    step();
    check("p1_on_done", 32'(m_last_g), 32'd1);
    idle_inputs();
    step();

    // Reset in the middle of a sweep.
    p0_access(1'b1, 7'd100, 16'h7777);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 40; i++) step();
    do_reset();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 7'd100;
    cnt = 0;
    for (int i = 0; i < 3 * DEPTH && p0_req; i++) begin
      step();
      if (m_last_g == 0) p0_req = 1'b0;
      else cnt++;
    end
    check("rst_gnt_wait", 32'(cnt), CLR_ON_RST ? 32'(DEPTH) : 32'd0);
    idle_inputs();
    step();

    // Read-first on overwrite.
    p0_access(1'b1, 7'd9, 16'hAAAA);
    p0_access(1'b1, 7'd9, 16'h5555);
    check("rf_old", 32'(rd_data), 32'hAAAA);
    check("rf_rv", 32'(p0_rvalid), 32'd0);
    p0_access(1'b0, 7'd9, 16'h0);
    check("rf_new", 32'(rd_data), 32'h5555);

    // Randomized traffic with occasional clears; requests held until granted.
    for (int i = 0; i < 2000; i++) begin
      if (!p0_req) begin
        p0_req   = ($urandom % 3) != 0;
        p0_we    = $urandom % 2;
        p0_addr  = ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom % 8);
        p0_wdata = DW'($urandom);
      end
      if (!p1_req) begin
        p1_req   = ($urandom % 3) != 0;
        p1_we    = $urandom % 2;
        p1_addr  = ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom % 8);
        p1_wdata = DW'($urandom);
      end
      clr_start = ($urandom % 200) == 0;
      step();
      if (m_last_g == 0) p0_req = 1'b0;
      if (m_last_g == 1) p1_req = 1'b0;
    end
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_clear_arbiter.md
Name: ram_clear_arbiter

Overview:
- Controller for a single-port, read-first synchronous RAM (1-cycle registered read, read-old-data on write).
- Shares the RAM between two requesters (P0, P1) with round-robin arbitration.
- Provides a hardware clear sequencer that writes zero to every location: the run-time equivalent of power-up initialization.
- Sits between two client engines and one block-RAM instance.

Parameters:
- ADDR_WIDTH, 7, RAM address width.
- DATA_WIDTH, 16, RAM word width.
- DEPTH, 1<<ADDR_WIDTH, number of words (localparam, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr_start  in  1  single-cycle request to start a full clear.
- clr_busy  out  1  high while the clear sweep runs.
- clr_done  out  1  one-cycle pulse on the cycle after the last clear write.
- p0_req / p1_req  in  1  access request; held until granted.
- p0_we / p1_we  in  1  1 = write, 0 = read; qualified by req.
- p0_addr / p1_addr  in  ADDR_WIDTH  access address.
- p0_wdata / p1_wdata  in  DATA_WIDTH  write data.
- p0_gnt / p1_gnt  out  1  combinational grant; the access is performed on this clock edge.
- p0_rvalid / p1_rvalid  out  1  rd_data valid for that port's read.
- rd_data  out  DATA_WIDTH  shared RAM output register.

Behaviour:
- States: SERVE, CLEAR.
- Reset values: state per Optional Feature; clr_cnt=0; clr_busy=0 (1 if entering CLEAR); clr_done=0; rvalid=0; rr_last=P1, so P0 wins the first contention.
- rd_data is not reset (block-RAM output register). It is undefined until the first rvalid.
- SERVE:
  - gnt is asserted only when state==SERVE, clr_start==0, and the port's req==1.
  - One requesting port: it is granted.
  - Both ports requesting: grant the port != rr_last.
  - rr_last updates to the granted port on every grant.
  - At most one gnt per cycle.
- Granted read: RAM read at that address. Next cycle: that port's rvalid=1 and rd_data=mem[addr]. Latency is 1 cycle; back-to-back reads give a result every cycle.
- Granted write: mem[addr]<=wdata. rd_data next cycle shows the old value (read-first), but rvalid stays 0.
- CLEAR entry:
  - clr_start in SERVE moves to CLEAR on the next edge.
  - clr_start has priority over requests in the same cycle: no grant that cycle.
- CLEAR sweep:
  - Writes 0 to address clr_cnt each cycle, for clr_cnt = 0..DEPTH-1 (DEPTH cycles).
  - All gnt=0 and all rvalid=0.
  - Pending reqs simply wait.
- CLEAR exit:
  - After the write to DEPTH-1: clr_cnt wraps to 0, state=SERVE, clr_busy=0, clr_done=1 for one cycle.
  - Requests can be granted in the same cycle clr_done is high.
- clr_start while busy is ignored; no restart and no queueing.
- Reset mid-clear aborts the sweep. Contents are partially cleared; the post-reset state is defined by the Optional Feature.
- A read granted on the cycle before CLEAR entry still returns rvalid with correct data on the following cycle.
- Address wrap is not possible: addresses are full-width, and every value 0..DEPTH-1 is legal.

Optional Feature:
- Macro: RAM_CLR_ON_RESET_EN.
- Defined: deassertion of rst_n enters CLEAR with clr_busy=1 and clr_cnt=0. A full DEPTH-cycle sweep runs before the first grant, then clr_done pulses.
- Undefined: reset enters SERVE. RAM contents rely on configuration-time zero initialization, and only clr_start triggers a clear.

Decomposition:
- Package ram_ctrl_pkg holds:
  - state enum {SERVE, CLEAR};
  - port-ID constants PORT0=0, PORT1=1;
  - default ADDR_WIDTH/DATA_WIDTH constants.
- Sub-module ram_sp_rf holds the read-first single-port RAM (we, a, di, registered do) with zero initialization.
- The arbiter, clear FSM and rvalid pipeline stay in the top.

Test Plan:
- Defaults: ADDR_WIDTH=7, DATA_WIDTH=16, DEPTH=128.
- P0 writes 0xBEEF at address 5, then reads address 5 -> p0_gnt each cycle; p0_rvalid=1 one cycle after the read grant, rd_data=0xBEEF; p1_rvalid=0.
- P0 and P1 both hold read requests for 4 cycles after reset -> grants alternate P0,P1,P0,P1; each rvalid follows its grant by exactly 1 cycle.
- Write 0x1234 at address 127, pulse clr_start -> clr_busy high for exactly 128 cycles, clr_done one pulse; a subsequent read of addresses 0 and 127 returns 0x0000.
- P1 request held during CLEAR, and clr_start re-pulsed mid-sweep -> no p1_gnt while busy; sweep length unchanged at 128; p1_gnt on the clr_done cycle.
- Assert rst_n=0 at sweep cycle 40, release -> with RAM_CLR_ON_RESET_EN a full 128-cycle sweep restarts from address 0; without it, state=SERVE and grants occur immediately.
- Write 0xAAAA at address 9, then write 0x5555 at address 9 -> rd_data after the second write shows 0xAAAA (read-first) and rvalid stays 0; a following read returns 0x5555.
